// File: rtl/writeback_stage.sv
// Final pipeline stage: retires one instruction per transfer, writes PC and register file,
// aligns/extends load data and stalls upstream while a single load is outstanding.
module writeback_stage #(
    parameter int unsigned REG_ADDR_BITS = 5,
    parameter int unsigned INSTRET_BITS  = 64,
    parameter int unsigned SUPPRESS_X0   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     ready,
    input  logic                     enable,
    input  logic [REG_ADDR_BITS-1:0] rd,
    input  logic [31:0]              next_pc,
    input  logic                     rd_value_write_enable,
    input  logic [31:0]              rd_value_write_data,
    input  logic                     read_issued,
    input  logic [1:0]               load_size,
    input  logic                     load_signed,
    input  logic [1:0]               load_byte_offset,
    input  logic [31:0]              mem_read_data,
    input  logic                     mem_read_data_valid,
    output logic                     pc_write_enable,
    output logic [31:0]              pc_write_data,
    output logic                     register_file_write_enable,
    output logic [REG_ADDR_BITS-1:0] register_file_write_addr,
    output logic [31:0]              register_file_write_data,
    output logic [INSTRET_BITS-1:0]  instret
);

    typedef enum logic {
        IDLE,
        WAIT_READ
    } state_t;

    state_t                   state;
    state_t                   next_state;
    logic                     capture;
    logic [REG_ADDR_BITS-1:0] rd_q;
    logic [31:0]              next_pc_q;
    logic [1:0]               load_size_q;
    logic                     load_signed_q;
    logic [1:0]               load_byte_offset_q;

    // Select the addressed byte/half lane and extend it to 32 bits.
    function automatic logic [31:0] extract_load(
        input logic [31:0] data,
        input logic [1:0]  size,
        input logic        sign_ext,
        input logic [1:0]  offset
    );
        logic [7:0]  byte_lane;
        logic [15:0] half_lane;
        logic [31:0] result;
        byte_lane = data[{offset, 3'b000} +: 8];
        half_lane = offset[1] ? data[31:16] : data[15:0];
        case (size)
            2'd0:    result = {{24{sign_ext & byte_lane[7]}}, byte_lane};
            2'd1:    result = {{16{sign_ext & half_lane[15]}}, half_lane};
            default: result = data;
        endcase
        return result;
    endfunction

    // Next-state and combinational retire outputs.
    always_comb begin
        next_state                 = state;
        capture                    = 1'b0;
        ready                      = 1'b0;
        pc_write_enable            = 1'b0;
        pc_write_data              = next_pc;
        register_file_write_enable = 1'b0;
        register_file_write_addr   = rd;
        register_file_write_data   = rd_value_write_data;

        case (state)
            IDLE: begin
                ready = 1'b1;
                if (enable) begin
                    if (!read_issued) begin
                        pc_write_enable            = 1'b1;
                        register_file_write_enable = rd_value_write_enable;
                    end else if (mem_read_data_valid) begin
                        pc_write_enable            = 1'b1;
                        register_file_write_enable = 1'b1;
                        register_file_write_data   = extract_load(mem_read_data, load_size,
                                                                  load_signed, load_byte_offset);
                    end else begin
                        capture    = 1'b1;
                        next_state = WAIT_READ;
                    end
                end
            end
            WAIT_READ: begin
                pc_write_data            = next_pc_q;
                register_file_write_addr = rd_q;
                register_file_write_data = extract_load(mem_read_data, load_size_q,
                                                        load_signed_q, load_byte_offset_q);
                if (mem_read_data_valid) begin
                    pc_write_enable            = 1'b1;
                    register_file_write_enable = 1'b1;
                    next_state                 = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase

        if ((SUPPRESS_X0 != 0) && (register_file_write_addr == '0)) begin
            register_file_write_enable = 1'b0;
        end

        if (reset) begin
            ready                      = 1'b0;
            pc_write_enable            = 1'b0;
            register_file_write_enable = 1'b0;
            capture                    = 1'b0;
            next_state                 = IDLE;
        end
    end

    // State register and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            instret <= '0;
        end else begin
            state <= next_state;
            if (pc_write_enable) begin
                instret <= instret + INSTRET_BITS'(1);
            end
        end
    end

    // Fields of the outstanding load, held until its data returns.
    always_ff @(posedge clk) begin
        if (capture) begin
            rd_q               <= rd;
            next_pc_q          <= next_pc;
            load_size_q        <= load_size;
            load_signed_q      <= load_signed;
            load_byte_offset_q <= load_byte_offset;
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed scenarios plus random traffic against a transaction-level model.
module tb_writeback_stage;

    localparam int unsigned RAB = 5;
    localparam int unsigned IB  = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           ready;
    logic           enable;
    logic [RAB-1:0] rd;
    logic [31:0]    next_pc;
    logic           rd_value_write_enable;
    logic [31:0]    rd_value_write_data;
    logic           read_issued;
    logic [1:0]     load_size;
    logic           load_signed;
    logic [1:0]     load_byte_offset;
    logic [31:0]    mem_read_data;
    logic           mem_read_data_valid;
    logic           pc_write_enable;
    logic [31:0]    pc_write_data;
    logic           register_file_write_enable;
    logic [RAB-1:0] register_file_write_addr;
    logic [31:0]    register_file_write_data;
    logic [IB-1:0]  instret;

    always #5 clk = ~clk;

    writeback_stage #(
        .REG_ADDR_BITS(RAB),
        .INSTRET_BITS (IB),
        .SUPPRESS_X0  (1)
    ) dut (
        .clk                       (clk),
        .reset                     (reset),
        .ready                     (ready),
        .enable                    (enable),
        .rd                        (rd),
        .next_pc                   (next_pc),
        .rd_value_write_enable     (rd_value_write_enable),
        .rd_value_write_data       (rd_value_write_data),
        .read_issued               (read_issued),
        .load_size                 (load_size),
        .load_signed               (load_signed),
        .load_byte_offset          (load_byte_offset),
        .mem_read_data             (mem_read_data),
        .mem_read_data_valid       (mem_read_data_valid),
        .pc_write_enable           (pc_write_enable),
        .pc_write_data             (pc_write_data),
        .register_file_write_enable(register_file_write_enable),
        .register_file_write_addr  (register_file_write_addr),
        .register_file_write_data  (register_file_write_data),
        .instret                   (instret)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: at most one pending load, described by its captured fields.
    bit          m_pend;
    logic [4:0]  m_rd;
    logic [31:0] m_pc;
    logic [1:0]  m_size;
    logic        m_sgn;
    logic [1:0]  m_off;
    int unsigned m_instret;

    // Outputs observed in the most recent cycle.
    logic        o_ready, o_pcwe, o_rfwe;
    logic [31:0] o_pc, o_rfdata;
    logic [4:0]  o_rfaddr;

    function automatic logic [31:0] ref_extract(input logic [31:0] d, input logic [1:0] sz,
                                                input logic sg, input logic [1:0] off);
        longint unsigned v;
        if (sz == 2'd0) begin
            v = (64'(d) >> (8 * int'(off))) % 256;
            if (sg && v >= 128) v = v + 64'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (64'(d) >> (16 * (int'(off) / 2))) % 65536;
            if (sg && v >= 32768) v = v + 64'hFFFF_0000;
        end else begin
            v = 64'(d);
        end
        return 32'(v);
    endfunction

    // One clock: compare combinational outputs mid-cycle, then registered state after the edge.
    task automatic cycle();
        bit          ret;
        bit          e_ready, e_rfwe;
        logic [31:0] e_pc, e_data;
        logic [4:0]  e_addr;
        bit          n_pend;
        int unsigned n_inst;
        ret = 0; e_ready = 0; e_rfwe = 0; e_pc = '0; e_data = '0; e_addr = '0;
        n_pend = m_pend; n_inst = m_instret;

        @(negedge clk);
        o_ready = ready; o_pcwe = pc_write_enable; o_rfwe = register_file_write_enable;
        o_pc = pc_write_data; o_rfdata = register_file_write_data; o_rfaddr = register_file_write_addr;

        if (reset) begin
            n_pend = 0;
            n_inst = 0;
        end else begin
            e_ready = !m_pend;
            if (!m_pend) begin
                if (enable) begin
                    if (!read_issued) begin
                        ret = 1; e_pc = next_pc; e_rfwe = rd_value_write_enable;
                        e_addr = rd; e_data = rd_value_write_data;
                    end else if (mem_read_data_valid) begin
                        ret = 1; e_pc = next_pc; e_rfwe = 1; e_addr = rd;
                        e_data = ref_extract(mem_read_data, load_size, load_signed, load_byte_offset);
                    end else begin
                        n_pend = 1; m_rd = rd; m_pc = next_pc;
                        m_size = load_size; m_sgn = load_signed; m_off = load_byte_offset;
                    end
                end
            end else if (mem_read_data_valid) begin
                ret = 1; e_pc = m_pc; e_rfwe = 1; e_addr = m_rd;
                e_data = ref_extract(mem_read_data, m_size, m_sgn, m_off);
                n_pend = 0;
            end
            if (e_addr == 0) e_rfwe = 0;
            if (ret) n_inst = (m_instret + 1) % (1 << IB);
        end

        check("ready", 64'(o_ready), 64'(e_ready));
        check("pc_we", 64'(o_pcwe), 64'(ret));
        if (ret) check("pc_data", 64'(o_pc), 64'(e_pc));
        check("rf_we", 64'(o_rfwe), 64'(e_rfwe));
        if (e_rfwe) begin
            check("rf_addr", 64'(o_rfaddr), 64'(e_addr));
            check("rf_data", 64'(o_rfdata), 64'(e_data));
        end

        @(posedge clk);
        #1;
        m_pend = n_pend;
        m_instret = n_inst;
        check("instret", 64'(instret), 64'(m_instret));
    endtask

    task automatic idle_inputs();
        enable = 0; rd = '0; next_pc = '0; rd_value_write_enable = 0; rd_value_write_data = '0;
        read_issued = 0; load_size = '0; load_signed = 0; load_byte_offset = '0;
        mem_read_data = '0; mem_read_data_valid = 0;
    endtask

    task automatic non_load(input logic [4:0] r, input logic [31:0] pc, input logic [31:0] d);
        idle_inputs();
        enable = 1; rd = r; next_pc = pc; rd_value_write_enable = 1; rd_value_write_data = d;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned prev;
        m_pend = 0; m_instret = 0;
        m_rd = '0; m_pc = '0; m_size = '0; m_sgn = 0; m_off = '0;
        idle_inputs();
        reset = 1;
        #1;
        cycle();
        cycle();
        check("reset_instret", 64'(instret), 64'd0);
        check("reset_ready", 64'(o_ready), 64'd0);
        reset = 0;

        // Non-load back-to-back
        for (int i = 0; i < 3; i++) begin
            non_load(5'd5, 32'h104 + 32'(4 * i), 32'hDEAD_BEEF);
            cycle();
            check("bb_pcwe", 64'(o_pcwe), 64'd1);
            check("bb_rfaddr", 64'(o_rfaddr), 64'd5);
        end
        idle_inputs();
        cycle();
        check("bb_instret", 64'(instret), 64'd3);

        // Stalled signed byte load, data three cycles after transfer
        idle_inputs();
        enable = 1; read_issued = 1; rd = 5'd7; next_pc = 32'h200;
        load_size = 2'd0; load_signed = 1; load_byte_offset = 2'd2;
        cycle();
        for (int i = 0; i < 2; i++) begin
            idle_inputs();
            enable = 1; rd = 5'd3; next_pc = 32'hBAD0; rd_value_write_enable = 1;
            load_size = 2'd2; load_signed = 0; load_byte_offset = 2'd1;
            cycle();
            check("stall_ready", 64'(o_ready), 64'd0);
        end
        mem_read_data = 32'h1280_FF00; mem_read_data_valid = 1;
        cycle();
        check("ld_ready", 64'(o_ready), 64'd0);
        check("ld_pcwe", 64'(o_pcwe), 64'd1);
        check("ld_pc", 64'(o_pc), 64'h200);
        check("ld_rfaddr", 64'(o_rfaddr), 64'd7);
        check("ld_rfdata", 64'(o_rfdata), 64'hFFFF_FF80);
        idle_inputs();
        cycle();
        check("ld_ready_after", 64'(o_ready), 64'd1);

        // Bypass load
        idle_inputs();
        enable = 1; read_issued = 1; mem_read_data_valid = 1; rd = 5'd9; next_pc = 32'h300;
        load_size = 2'd1; load_signed = 0; load_byte_offset = 2'd2; mem_read_data = 32'hBEEF_1234;
        cycle();
        check("byp_ready", 64'(o_ready), 64'd1);
        check("byp_pcwe", 64'(o_pcwe), 64'd1);
        check("byp_rfdata", 64'(o_rfdata), 64'h0000_BEEF);
        idle_inputs();
        cycle();
        check("byp_ready_after", 64'(o_ready), 64'd1);

        // x0 suppression
        prev = 32'(instret);
        non_load(5'd0, 32'h400, 32'h1234_5678);
        cycle();
        check("x0_rfwe", 64'(o_rfwe), 64'd0);
        check("x0_pcwe", 64'(o_pcwe), 64'd1);
        check("x0_instret", 64'(instret), 64'((prev + 1) % 16));

        // Reset mid-load, late data is spurious
        idle_inputs();
        enable = 1; read_issued = 1; rd = 5'd4; next_pc = 32'h500;
        cycle();
        idle_inputs();
        reset = 1;
        cycle();
        reset = 0;
        mem_read_data_valid = 1; mem_read_data = 32'hFFFF_FFFF;
        cycle();
        check("rst_pcwe", 64'(o_pcwe), 64'd0);
        check("rst_ready", 64'(o_ready), 64'd1);
        check("rst_instret", 64'(instret), 64'd0);

        // Counter wrap with a 4-bit counter
        for (int i = 0; i < 17; i++) begin
            non_load(5'(i + 1), 32'h600 + 32'(4 * i), 32'(i));
            cycle();
        end
        check("wrap_instret", 64'(instret), 64'd1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            reset                 = ($urandom_range(0, 59) == 0);
            enable                = ($urandom_range(0, 9) < 7);
            read_issued           = ($urandom_range(0, 9) < 4);
            mem_read_data_valid   = ($urandom_range(0, 9) < 3);
            rd                    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            next_pc               = $urandom;
            rd_value_write_enable = 1'($urandom);
            rd_value_write_data   = $urandom;
            load_size             = 2'($urandom);
            load_signed           = 1'($urandom);
            load_byte_offset      = 2'($urandom);
            mem_read_data         = $urandom;
            cycle();
        end
        reset = 0;
        idle_inputs();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
